clk_div_meter: RTL

CLK_DIV_METER -- requirements
Module: clk_div_meter

---
 rtl/clk_util_pkg.sv | 5 +
 rtl/sync_2ff.sv | 16 +
 rtl/clk_div_meter.sv | 91 +++++++++
 3 files changed

// File: rtl/clk_util_pkg.sv
// clk_util_pkg: shared clock-utility types and defaults (meter FSM encoding, default counter width)
package clk_util_pkg;
    localparam int CNT_W_DEF = 8;
    typedef enum logic {WAIT_EDGE = 1'b0, MEASURE = 1'b1} meter_state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit
//   clk_in : destination clock
//   rst    : asynchronous active-high reset, clears both flops
//   d      : asynchronous input
//   q      : synchronized output (second flop)
module sync_2ff (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1;
    always_ff @(posedge clk_in or posedge rst)
        if (rst) {q, s1} <= 2'b00;
        else     {q, s1} <= {s1, d};
endmodule

// File: rtl/clk_div_meter.sv
// clk_div_meter: measures period and high time of a divided clock in clk_in cycles
//   clk_in     : system clock
//   rst        : asynchronous active-high reset
//   en         : measurement enable
//   div_in     : asynchronous divided clock under measurement
//   period     : clk_in cycles between consecutive div_in rising edges
//   high_cnt   : clk_in cycles div_in was sampled high within that period
//   meas_valid : one-cycle pulse when period/high_cnt update
//   timeout    : one-cycle pulse when the period counter saturates without an edge
module clk_div_meter import clk_util_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             timeout
);
    localparam logic [CNT_W-1:0] ONES = '1;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    meter_state_e     state, state_nxt;
    logic             s2, s3, rise;
    logic [CNT_W-1:0] cnt, cnt_nxt, hcnt, hcnt_nxt, period_nxt, high_nxt;
    logic             mv_nxt, to_nxt;

    sync_2ff u_sync (.clk_in(clk_in), .rst(rst), .d(div_in), .q(s2));

    assign rise = s2 & ~s3;

    always_ff @(posedge clk_in or posedge rst)
        if (rst) begin
            s3         <= 1'b0;
            state      <= WAIT_EDGE;
            cnt        <= '0;
            hcnt       <= '0;
            period     <= '0;
            high_cnt   <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            s3         <= s2;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            hcnt       <= hcnt_nxt;
            period     <= period_nxt;
            high_cnt   <= high_nxt;
            meas_valid <= mv_nxt;
            timeout    <= to_nxt;
        end

    // The rising-edge cycle itself counts as the first (high) cycle of the new period,
    // so both counters restart at 1; a rise at cnt==ONES wins over the timeout.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hcnt_nxt   = hcnt;
        period_nxt = period;
        high_nxt   = high_cnt;
        mv_nxt     = 1'b0;
        to_nxt     = 1'b0;
        if (!en) begin
            state_nxt = WAIT_EDGE;
            cnt_nxt   = '0;
            hcnt_nxt  = '0;
        end else if (state == WAIT_EDGE) begin
            if (rise) begin
                state_nxt = MEASURE;
                cnt_nxt   = ONE;
                hcnt_nxt  = ONE;
            end
        end else if (rise) begin
            period_nxt = cnt;
            high_nxt   = hcnt;
            mv_nxt     = 1'b1;
            cnt_nxt    = ONE;
            hcnt_nxt   = ONE;
        end else if (cnt == ONES) begin
            to_nxt    = 1'b1;
            state_nxt = WAIT_EDGE;
            cnt_nxt   = '0;
            hcnt_nxt  = '0;
        end else begin
            cnt_nxt  = cnt + ONE;
            hcnt_nxt = (s2 && hcnt != ONES) ? hcnt + ONE : hcnt;
        end
    end
endmodule
